// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - shared constants and types for the MCU SPI bridge
//
// Holds the downstream target ids, the bridge FSM state encoding and the
// byte sent on MISO when no target reply is due.

package mcu_spi_pkg;

    // Target ids carried in the first byte of every frame
    localparam logic [7:0] TGT_SYS = 8'd0;
    localparam logic [7:0] TGT_HID = 8'd1;
    localparam logic [7:0] TGT_OSD = 8'd2;
    localparam logic [7:0] TGT_SDC = 8'd3;

    // Byte shifted out when no reply is pending (id byte, first data byte, bad id)
    localparam logic [7:0] IDLE_REPLY = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ID   = 2'd1,
        ST_DATA = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/mcu_spi_bridge_spi_in_sync.sv
// rtl/mcu_spi_bridge_spi_in_sync.sv - SPI pin synchronisers and edge detectors
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_csn/sclk/mosi raw asynchronous SPI pins
//   csn               synchronised chip select level
//   csn_fall          one-cycle pulse on a synchronised csn falling edge
//   sclk_rise/fall    one-cycle pulses on synchronised SCK edges
//   mosi              synchronised MOSI, aligned with the SCK edge pulses

module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_csn,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic csn,
    output logic csn_fall,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   csn_prev;
    logic                   sclk_prev;

    // csn resets to "deselected" so a low pin after reset looks like a falling
    // edge; the bridge ignores it because it starts in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            csn_sync  <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            csn_prev  <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            csn_prev  <= csn_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign csn       = csn_sync[SYNC_STAGES-1];
    assign csn_fall  = csn_prev & ~csn_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];
    assign mosi      = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_spi_bridge.sv
// rtl/mcu_spi_bridge.sv - SPI slave demultiplexing MCU byte frames to core targets
//
// Frame: csn low, one target id byte, then any number of data bytes. Each
// data byte is handed to the selected target with a one-cycle tgt_strobe;
// the target's reply to byte k is shifted out on MISO during byte k+1.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   spi_csn      MCU chip select (active-low, asynchronous)
//   spi_sclk     SPI clock, mode 0, asynchronous, at most clk/8
//   spi_mosi     MCU->FPGA data, MSB first
//   spi_miso     FPGA->MCU data, MSB first
//   tgt_strobe   one-hot, one-cycle pulse per data byte delivered
//   tgt_start    high with tgt_strobe for the first data byte of a frame
//   tgt_data     byte delivered with tgt_strobe
//   tgt_reply    reply byte per target, target n at [8n+7:8n]
//
// Optional build macro MCU_SPI_TIMEOUT_EN: aborts a frame to WAIT after
// TIMEOUT clk cycles without an SCK edge.

module mcu_spi_bridge
    import mcu_spi_pkg::*;
#(
    parameter int TARGETS     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_csn,
    input  logic                   spi_sclk,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [TARGETS-1:0]     tgt_strobe,
    output logic                   tgt_start,
    output logic [7:0]             tgt_data,
    input  logic [8*TARGETS-1:0]   tgt_reply
);

    logic csn, csn_fall, sclk_rise, sclk_fall, mosi;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk       (clk),
        .reset     (reset),
        .spi_csn   (spi_csn),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .csn       (csn),
        .csn_fall  (csn_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi      (mosi)
    );

    state_t             state, state_next;
    logic [2:0]         bit_cnt;
    logic [7:0]         rx_shift;
    logic [7:0]         id;
    logic [7:0]         tx_shift;
    logic               first_byte;
    logic               load_p1, load_p2;
    logic               sel_p1, sel_p2;
    logic               timeout;
    logic               in_id, in_data, in_frame, clear_tx;
    logic [7:0]         rx_byte;
    logic               byte_done;
    logic               id_valid;
    logic [TARGETS-1:0] id_onehot;
    logic [7:0]         sel_reply;

    assign rx_byte   = {rx_shift[6:0], mosi};
    // csn high takes priority over a byte-completing edge in the same cycle
    assign byte_done = in_frame && !csn && !timeout && sclk_rise && (bit_cnt == 3'd7);
    assign id_valid  = (int'(id) < TARGETS);

    always_comb begin
        id_onehot = '0;
        sel_reply = IDLE_REPLY;
        for (int n = 0; n < TARGETS; n++) begin
            if (id == 8'(n)) begin
                id_onehot[n] = 1'b1;
                sel_reply    = tgt_reply[8*n +: 8];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: if (csn)      state_next = ST_IDLE;
            ST_IDLE: if (csn_fall) state_next = ST_ID;
            ST_ID: begin
                if (csn)            state_next = ST_IDLE;
                else if (timeout)   state_next = ST_WAIT;
                else if (byte_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (csn)            state_next = ST_IDLE;
                else if (timeout)   state_next = ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // ---------------- FSM: state decode ----------------
    always_comb begin
        in_id    = (state == ST_ID);
        in_data  = (state == ST_DATA);
        in_frame = in_id || in_data;
        clear_tx = (state == ST_IDLE) || (state == ST_WAIT);
    end

    // ---------------- receive path and target strobes ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            id         <= 8'h00;
            first_byte <= 1'b0;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_data   <= 8'h00;
            load_p1    <= 1'b0;
            load_p2    <= 1'b0;
            sel_p1     <= 1'b0;
            sel_p2     <= 1'b0;
        end else begin
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            // Reply-load pipeline: byte done at T, target sees strobe at T+1,
            // MISO register takes the reply at T+2.
            load_p1    <= byte_done;
            sel_p1     <= byte_done && in_data && id_valid;
            load_p2    <= load_p1;
            sel_p2     <= sel_p1;

            if (!in_frame) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (sclk_rise && !csn && !timeout) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end

            if (byte_done && in_id) begin
                id         <= rx_byte;
                first_byte <= 1'b1;
            end

            if (byte_done && in_data) begin
                first_byte <= 1'b0;
                if (id_valid) begin
                    tgt_strobe <= id_onehot;
                    tgt_start  <= first_byte;
                    tgt_data   <= rx_byte;
                end
            end
        end
    end

    // ---------------- transmit path ----------------
    // The falling edge that follows a byte's last rising edge sees bit_cnt==0;
    // it must not shift, so the freshly loaded bit 7 stays on MISO.
    always_ff @(posedge clk) begin
        if (reset || clear_tx) begin
            tx_shift <= 8'h00;
        end else if (load_p2) begin
            tx_shift <= sel_p2 ? sel_reply : IDLE_REPLY;
        end else if (in_frame && sclk_fall && (bit_cnt != 3'd0)) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    assign spi_miso = tx_shift[7];

    // ---------------- optional SCK stall timeout ----------------
`ifdef MCU_SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || !in_frame || sclk_rise || sclk_fall) tmo_cnt <= '0;
        else if (!timeout)                               tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign timeout = (tmo_cnt == TW'(TIMEOUT));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// tb/tb_mcu_spi_bridge.sv - self-checking bench for mcu_spi_bridge

module tb_mcu_spi_bridge;
    import mcu_spi_pkg::*;

    localparam int TARGETS = 4;
    localparam int HALF    = 6;
`ifdef MCU_SPI_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 spi_csn = 1'b1;
    logic                 spi_sclk = 1'b0;
    logic                 spi_mosi = 1'b0;
    logic                 spi_miso;
    logic [TARGETS-1:0]   tgt_strobe;
    logic                 tgt_start;
    logic [7:0]           tgt_data;
    logic [8*TARGETS-1:0] tgt_reply;

    always #5 clk = ~clk;

    mcu_spi_bridge #(
        .TARGETS     (TARGETS),
        .SYNC_STAGES (2),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .tgt_strobe (tgt_strobe),
        .tgt_start  (tgt_start),
        .tgt_data   (tgt_data),
        .tgt_reply  (tgt_reply)
    );

    typedef struct packed {
        logic [7:0] tgt;
        logic [7:0] data;
        logic       start;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rep_q[$];
    logic [7:0] exp_rep[$];
    logic [7:0] frame_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] reply_reg [TARGETS] = '{default: 8'h00};
    logic [TARGETS-1:0] prev_strobe = '0;
    int checks = 0;
    int failures = 0;
    int consec_err = 0;
    int onehot_err = 0;

    always_comb begin
        tgt_reply = '0;
        for (int n = 0; n < TARGETS; n++) tgt_reply[8*n +: 8] = reply_reg[n];
    end

    // Target model: logs each delivered byte and registers its next reply
    always @(negedge clk) begin
        for (int n = 0; n < TARGETS; n++) begin
            if (tgt_strobe[n] === 1'b1) begin
                ev_q.push_back('{tgt: 8'(n), data: tgt_data, start: tgt_start});
                reply_reg[n] = (rep_q.size() > 0) ? rep_q.pop_front() : 8'hEE;
            end
        end
        if (!reset && !$onehot0(tgt_strobe)) onehot_err++;
        if (tgt_strobe != '0 && prev_strobe != '0) consec_err++;
        prev_strobe = tgt_strobe;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            tick(HALF);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic open_frame();
        ev_q.delete();
        miso_q.delete();
        spi_csn = 1'b0;
        tick(HALF);
    endtask

    task automatic send_bytes();
        logic [7:0] rx;
        foreach (frame_q[i]) begin
            spi_bits(frame_q[i], 8, rx);
            miso_q.push_back(rx);
        end
    endtask

    task automatic close_frame(input int gap);
        tick(HALF);
        spi_csn = 1'b1;
        tick(gap);
    endtask

    task automatic run_frame(input int gap);
        rep_q = exp_rep;
        open_frame();
        send_bytes();
        close_frame(gap);
    endtask

    // Reference: valid id gets every data byte in order, start on the first;
    // MISO byte j carries the reply to data byte j-2, zero otherwise.
    task automatic check_frame(input string tag);
        int id, nd, exp_n, e;
        id    = int'(frame_q[0]);
        nd    = frame_q.size() - 1;
        exp_n = (id < TARGETS) ? nd : 0;
        chk({tag, " strobe_count"}, ev_q.size(), exp_n);
        for (int k = 0; k < exp_n && k < ev_q.size(); k++) begin
            chk($sformatf("%s tgt[%0d]", tag, k), int'(ev_q[k].tgt), id);
            chk($sformatf("%s data[%0d]", tag, k), int'(ev_q[k].data), int'(frame_q[k+1]));
            chk($sformatf("%s start[%0d]", tag, k), int'(ev_q[k].start), (k == 0) ? 1 : 0);
        end
        for (int j = 0; j < miso_q.size(); j++) begin
            e = (j < 2 || id >= TARGETS) ? 0 : int'(exp_rep[j-2]);
            chk($sformatf("%s miso[%0d]", tag, j), int'(miso_q[j]), e);
        end
    endtask

    initial begin
        logic [7:0] rx;
        int nd;

        // Reset values
        tick(3);
        chk("reset strobe", int'(tgt_strobe), 0);
        chk("reset start", int'(tgt_start), 0);
        chk("reset data", int'(tgt_data), 0);
        chk("reset miso", int'(spi_miso), 0);
        reset = 1'b0;
        tick(4);

        // Target 0, four data bytes, replies 5C/42/01
        frame_q = '{TGT_SYS, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_rep = '{8'h5C, 8'h42, 8'h01, 8'h00};
        run_frame(4);
        check_frame("sys_frame");

        // Target 1, two data bytes
        frame_q = '{TGT_HID, 8'h07, 8'hA5};
        exp_rep = '{8'h3E, 8'h81};
        run_frame(4);
        check_frame("hid_frame");

        // Out-of-range id
        frame_q = '{8'h09, 8'h11, 8'h22, 8'h33};
        exp_rep = '{8'h91, 8'h92, 8'h93};
        run_frame(4);
        check_frame("bad_id");

        // csn raised after 5 bits of the second data byte
        frame_q = '{TGT_SYS, 8'h5A};
        exp_rep = '{8'h10};
        rep_q = exp_rep;
        open_frame();
        send_bytes();
        spi_bits(8'hC3, 5, rx);
        close_frame(4);
        chk("partial strobe_count", ev_q.size(), 1);
        if (ev_q.size() > 0) chk("partial data", int'(ev_q[0].data), 8'h5A);
        frame_q = '{TGT_SYS, 8'h03};
        exp_rep = '{8'h20};
        run_frame(4);
        check_frame("after_partial");

        // csn rises together with the byte-completing SCK edge
        frame_q = '{TGT_OSD, 8'hAA};
        exp_rep = '{8'h30, 8'h31};
        rep_q = exp_rep;
        open_frame();
        send_bytes();
        spi_bits(8'h55, 7, rx);
        spi_mosi = 1'b1;
        tick(HALF);
        spi_sclk = 1'b1;
        spi_csn = 1'b1;
        tick(HALF);
        spi_sclk = 1'b0;
        tick(HALF);
        chk("collide strobe_count", ev_q.size(), 1);

        // Reset mid-byte, released while csn is still low
        open_frame();
        spi_bits(TGT_HID, 8, rx);
        spi_bits(8'h77, 3, rx);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        spi_bits(8'h77, 5, rx);
        spi_bits(8'h12, 8, rx);
        spi_bits(8'h34, 8, rx);
        chk("reset_mid strobe_count", ev_q.size(), 0);
        close_frame(4);
        frame_q = '{TGT_HID, 8'h44, 8'h45};
        exp_rep = '{8'h50, 8'h51};
        run_frame(4);
        check_frame("after_reset");

`ifdef MCU_SPI_TIMEOUT_EN
        // SCK stalls mid-byte; later edges are ignored until csn toggles
        frame_q = '{TGT_SYS, 8'h11};
        exp_rep = '{8'h60};
        rep_q = exp_rep;
        open_frame();
        send_bytes();
        spi_bits(8'h22, 3, rx);
        tick(100);
        spi_bits(8'h22, 5, rx);
        spi_bits(8'h66, 8, rx);
        chk("timeout strobe_count", ev_q.size(), 1);
        if (ev_q.size() > 0) chk("timeout data", int'(ev_q[0].data), 8'h11);
        close_frame(4);
        frame_q = '{TGT_SYS, 8'h33};
        exp_rep = '{8'h61};
        run_frame(4);
        check_frame("after_timeout");
`endif

        // Random frames; odd frames leave only one csn-high sample before the next
        for (int f = 0; f < 8; f++) begin
            nd = $urandom_range(1, 5);
            frame_q.delete();
            exp_rep.delete();
            frame_q.push_back(8'($urandom_range(0, 5)));
            for (int k = 0; k < nd; k++) begin
                frame_q.push_back(8'($urandom));
                exp_rep.push_back(8'($urandom));
            end
            run_frame((f % 2 == 1) ? 1 : $urandom_range(2, 5));
            check_frame($sformatf("rand%0d", f));
        end

        tick(10);
        chk("strobe onehot", onehot_err, 0);
        chk("strobe back_to_back", consec_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
